// File: rtl/test_signal_gen_if.sv
// Handshake and table-write bundle for test_signal_gen.
// Run control in, sample stream and status out; master drives, slave is the generator.
interface test_signal_gen_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [3:0]        shift;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] d;
    logic              d_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sample_idx;

    modport master (
        output start, abort, mode, shift,
        output wr_en, wr_addr, wr_data,
        input  d, d_valid, busy, done, sample_idx
    );

    modport slave (
        input  start, abort, mode, shift,
        input  wr_en, wr_addr, wr_data,
        output d, d_valid, busy, done, sample_idx
    );
endinterface

// File: rtl/test_signal_gen.sv
// Test stimulus generator: zero / step / impulse / table playback with attenuation.
// Ports: clk, reset (sync, active-high), bus = test_signal_gen_if.slave.
module test_signal_gen #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int RUN_LEN = 20
) (
    input  logic             clk,
    input  logic             reset,
    test_signal_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        RUN
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_TBL = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_RUN = ADDR_W'(RUN_LEN - 1);
    localparam logic signed [DATA_W-1:0] FULL_SCALE =
        {1'b0, {(DATA_W-1){1'b1}}};

    state_t state;
    state_t state_nxt;

    logic [1:0]               mode_q;
    logic [3:0]               shift_q;
    logic [ADDR_W-1:0]        rd_idx;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        last_idx;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DATA_W-1:0]        ram_q;
    logic signed [DATA_W-1:0] raw;
    logic signed [DATA_W-1:0] shifted;
    logic [DATA_W-1:0]        d_q;
    logic                     dv_q;
    logic [ADDR_W-1:0]        idx_q;
    logic                     done_q;
    logic                     accept;
    logic                     emit;
    logic                     finish;
    logic                     last_out;
    logic                     wr_ok;

    // Table is writable only while idle; reset also blocks the write.
    assign wr_ok = bus.wr_en && (state == IDLE) && !reset;

    assign last_idx = (mode_q == 2'd3) ? LAST_TBL : LAST_RUN;

    // The final sample is on d during one extra RUN cycle; the edge
    // that ends it is the one that returns to IDLE with done.
    assign last_out = dv_q && (idx_q == last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        finish    = 1'b0;
        rd_addr   = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = PREFETCH;
                    accept    = 1'b1;
                end
            end
            PREFETCH: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (last_out) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    emit    = 1'b1;
                    // Fetch one ahead so ram_q holds the next sample.
                    rd_addr = rd_idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        raw = '0;
        unique case (mode_q)
            2'd0: raw = '0;
            2'd1: raw = FULL_SCALE;
            2'd2: raw = (rd_idx == '0) ? FULL_SCALE : '0;
            default: raw = $signed(ram_q);
        endcase
    end

    assign shifted = raw >>> shift_q;

    // Synchronous-read table; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= '0;
            shift_q <= '0;
            rd_idx  <= '0;
            d_q     <= '0;
            dv_q    <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                mode_q  <= bus.mode;
                shift_q <= bus.shift;
            end
            if (emit) begin
                d_q    <= shifted;
                dv_q   <= 1'b1;
                idx_q  <= rd_idx;
                rd_idx <= rd_idx + 1'b1;
            end else begin
                d_q    <= '0;
                dv_q   <= 1'b0;
                idx_q  <= '0;
                rd_idx <= '0;
            end
        end
    end

    assign bus.d          = d_q;
    assign bus.d_valid    = dv_q;
    assign bus.sample_idx = idx_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_test_signal_gen.sv
// Scoreboard bench for test_signal_gen.
// Stimulus pushes expected samples; a monitor pops and compares each output.
module tb_test_signal_gen;
    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        int          edge_no;
        bit          is_done;
        logic [15:0] data;
        logic [9:0]  idx;
    } exp_t;

    exp_t               sbq[$];
    logic signed [15:0] tbl [1024];

    test_signal_gen_if #(.DATA_W(16), .ADDR_W(10)) bus ();

    test_signal_gen #(
        .DATA_W(16),
        .ADDR_W(10),
        .RUN_LEN(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] m,
                                          input logic [3:0] sh,
                                          input int i);
        logic signed [15:0] r;
        case (m)
            2'd0: r = 16'sh0000;
            2'd1: r = 16'sh7FFF;
            2'd2: r = (i == 0) ? 16'sh7FFF : 16'sh0000;
            default: r = tbl[i];
        endcase
        return r >>> sh;
    endfunction

    // Issues start at the current negedge; sampled at edge k = cyc+1.
    task automatic launch(input logic [1:0] m, input logic [3:0] sh,
                          input int cnt, input bit with_done,
                          output int k);
        exp_t e;
        int   n;
        n = (m == 2'd3) ? 1024 : 20;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.shift = sh;
        k = cyc + 1;
        for (int i = 0; i < cnt; i++) begin
            e.edge_no = k + 2 + i;
            e.is_done = 1'b0;
            e.data    = model(m, sh, i);
            e.idx     = 10'(i);
            sbq.push_back(e);
        end
        if (with_done) begin
            e.edge_no = k + n + 2;
            e.is_done = 1'b1;
            e.data    = 16'h0000;
            e.idx     = 10'h000;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.d_valid || bus.done) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out edge %0d: d=%h v=%b done=%b idx=%0d, required none",
                             cyc, bus.d, bus.d_valid, bus.done, bus.sample_idx);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.edge_no || bus.done !== e.is_done ||
                        bus.d_valid !== !e.is_done || bus.d !== e.data ||
                        bus.sample_idx !== e.idx) begin
                        n_bad++;
                        $display("FAIL sample edge %0d: d=%h v=%b done=%b idx=%0d, required edge %0d d=%h done=%b idx=%0d",
                                 cyc, bus.d, bus.d_valid, bus.done, bus.sample_idx,
                                 e.edge_no, e.data, e.is_done, e.idx);
                    end
                end
            end else if (bus.d !== 16'h0000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_d edge %0d: got %h, required 0000", cyc, bus.d);
            end
        end
    end

    initial begin
        int k;
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.mode    = 2'd0;
        bus.shift   = 4'd0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);

        check("rst_d", 32'(bus.d), 32'h0);
        check("rst_valid", 32'(bus.d_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_idx", 32'(bus.sample_idx), 32'h0);

        // Step, started on the first edge out of reset.
        reset = 1'b0;
        launch(2'd1, 4'd0, 20, 1'b1, k);
        check("step_busy", 32'(bus.busy), 32'h1);
        wait_until(k + 22);
        check("step_done", 32'(bus.done), 32'h1);
        check("step_done_busy", 32'(bus.busy), 32'h0);

        // Impulse with shift 1, started in the done cycle.
        launch(2'd2, 4'd1, 20, 1'b1, k);
        wait_until(k + 22);
        check("imp_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'h0);

        // Zero mode with start and abort together: start wins.
        bus.abort = 1'b1;
        launch(2'd0, 4'd3, 20, 1'b1, k);
        check("start_over_abort", 32'(bus.busy), 32'h1);
        wait_until(k + 23);

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'h0);

        // Abort in the 5th RUN cycle of a step run.
        launch(2'd1, 4'd0, 4, 1'b0, k);
        wait_until(k + 5);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_valid", 32'(bus.d_valid), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_idx", 32'(bus.sample_idx), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        launch(2'd2, 4'd0, 20, 1'b1, k);
        check("restart_busy", 32'(bus.busy), 32'h1);
        wait_until(k + 23);

        // Fill the table; address 0 gets a throwaway value first.
        for (int i = 0; i < 1024; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 10'(i);
            bus.wr_data = (i == 0) ? 16'h5555 : 16'(i * 64 - 32768);
            tbl[i]      = (i == 0) ? 16'sh5555 : 16'(i * 64 - 32768);
            @(negedge clk);
        end

        // Final address-0 write lands in the same cycle as start.
        bus.wr_en   = 1'b1;
        bus.wr_addr = 10'd0;
        bus.wr_data = 16'h8000;
        tbl[0]      = 16'sh8000;
        launch(2'd3, 4'd15, 1024, 1'b1, k);

        // Blocked write, start and input changes mid-run.
        wait_until(k + 300);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 10'd0;
        bus.wr_data = 16'h1234;
        bus.start   = 1'b1;
        bus.mode    = 2'd1;
        bus.shift   = 4'd0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_until(k + 1026);
        check("tbl_done", 32'(bus.done), 32'h1);
        @(negedge clk);

        // Reset at the 100th sample of a table run.
        launch(2'd3, 4'd0, 100, 1'b0, k);
        wait_until(k + 101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_d", 32'(bus.d), 32'h0);
        check("mrst_valid", 32'(bus.d_valid), 32'h0);
        check("mrst_busy", 32'(bus.busy), 32'h0);
        check("mrst_done", 32'(bus.done), 32'h0);
        check("mrst_idx", 32'(bus.sample_idx), 32'h0);

        // Rerun shows table intact and the blocked write dropped.
        launch(2'd3, 4'd0, 1024, 1'b1, k);
        wait_until(k + 1027);
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
